// File: rtl/apb_master_bridge.sv
// APB master bridge: single-outstanding requester for a two-slave APB bus.
// Takes one command at a time on a valid/ready interface and runs it through
// IDLE -> SETUP -> ACCESS. The response is a one-cycle strobe that carries the
// read data, or a timeout error flag if the slave stalls for too long.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_sel,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // A timeout of zero disables the abort path, so the compare value only
  // matters when the timeout is enabled.
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t           state_q;
  logic             sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             psel1_q;
  logic             psel2_q;
  logic             penable_q;
  logic             pwrite_q;
  logic [7:0]       paddr_q;
  logic [7:0]       pwdata_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic             rsp_err_q;
  logic             pready_sel;
  logic [7:0]       prdata_sel;
  logic             timeout_hit;

  // Route the latched slave's handshake back to the FSM; the wait counter
  // saturates instead of wrapping.
  always_comb begin
    pready_sel  = sel_q ? PREADY2 : PREADY1;
    prdata_sel  = sel_q ? PRDATA2 : PRDATA1;
    timeout_hit = TO_EN && (cnt_q == TO_LAST);
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  assign cmd_ready = (state_q == IDLE) && PRESETn;

  // Transfer sequencer with registered bus and response outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          psel1_q   <= 1'b0;
          psel2_q   <= 1'b0;
          penable_q <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            sel_q    <= cmd_sel;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : 8'h00;
            psel1_q  <= ~cmd_sel;
            psel2_q  <= cmd_sel;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_sel) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? 8'h00 : prdata_sel;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 8'h00;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          psel1_q   <= 1'b0;
          psel2_q   <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: two memory-backed APB slaves with
// programmable wait states, a reference memory, and a response scoreboard.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  // Slave models: memory loaded from the reference image during reset,
  // PREADY held low for wt[] ACCESS cycles, or forever when tie[] is set.
  logic [7:0] refm [2][256];
  logic [7:0] smem [2][256];
  int         acc  [2];
  int         wt   [2];
  bit         tie  [2];

  assign PRDATA1 = smem[0][PADDR];
  assign PRDATA2 = smem[1][PADDR];
  assign PREADY1 = !tie[0] && (acc[0] >= wt[0]);
  assign PREADY2 = !tie[1] && (acc[1] >= wt[1]);

  always @(posedge PCLK) begin
    acc[0] <= (PSEL1 && PENABLE && !PREADY1) ? acc[0] + 1 : 0;
    acc[1] <= (PSEL2 && PENABLE && !PREADY2) ? acc[1] + 1 : 0;
    if (!PRESETn) smem <= refm;
    else begin
      if (PSEL1 && PENABLE && PREADY1 && PWRITE) smem[0][PADDR] <= PWDATA;
      if (PSEL2 && PENABLE && PREADY2 && PWRITE) smem[1][PADDR] <= PWDATA;
    end
  end

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
    int         nsel;
    logic       sel;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         acc_c;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          nsel = 0;
  int          noth = 0;
  bit          seen = 0;
  logic [16:0] cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus and response monitor, sampled on the falling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge PCLK);
      cyc++;
      chk("bus_legal", {30'd0, PSEL1 & PSEL2, PENABLE & ~PSEL1 & ~PSEL2}, 0);
      if (PSEL1 || PSEL2) begin
        if (q.size() == 0) chk("psel_without_cmd", 1, 0);
        else begin
          if (q[0].sel) begin nsel += int'(PSEL2); noth += int'(PSEL1); end
          else          begin nsel += int'(PSEL1); noth += int'(PSEL2); end
          if (!seen) begin
            chk("setup_penable", PENABLE, 0);
            chk("setup_addr", PADDR, q[0].addr);
            chk("setup_write", PWRITE, q[0].wr);
            chk("setup_wdata", PWDATA, q[0].wr ? q[0].wdata : 8'h00);
            cap  = {PADDR, PWRITE, PWDATA};
            seen = 1;
          end else begin
            chk("access_penable", PENABLE, 1);
            chk("access_stable", {PADDR, PWRITE, PWDATA}, cap);
          end
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_latency", cyc - e.acc_c, e.lat);
          chk("psel_cycles", nsel, e.nsel);
          chk("psel_other", noth, 0);
          chk("ready_with_rsp", cmd_ready, 1);
        end
        nsel = 0;
        noth = 0;
        seen = 0;
      end
    end
  endtask

  // Present one command and wait (bounded) for it to be accepted.
  // cmd_valid is left high so consecutive calls form a back-to-back stream.
  task automatic issue(input logic wr, input logic sel, input logic [7:0] addr,
                       input logic [7:0] wd, input int waits, input bit to,
                       output int acc_c);
    exp_t e;
    int   n;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge PCLK); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      acc_c = cyc;
      return;
    end
    wt[int'(sel)]  = waits;
    tie[int'(sel)] = to;
    @(posedge PCLK); #1;
    acc_c   = cyc;
    e.err   = to;
    e.rdata = (to || wr) ? 8'h00 : refm[int'(sel)][addr];
    e.lat   = to ? 2 + TO : 3 + waits;
    e.nsel  = to ? 1 + TO : 2 + waits;
    e.sel   = sel; e.wr = wr; e.addr = addr; e.wdata = wd; e.acc_c = acc_c;
    if (wr && !to) refm[int'(sel)][addr] = wd;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge PCLK); n++; end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int a, prev;
    logic wr, sel;
    logic [7:0] ad, wd;
    int w;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0;
    cmd_addr = 8'h00; cmd_wdata = 8'h00;
    for (int s = 0; s < 2; s++) begin
      wt[s] = 0; tie[s] = 0;
      for (int i = 0; i < 256; i++) refm[s][i] = 8'($urandom);
    end
    refm[0][8'h80] = 8'h5A;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(posedge PCLK);
    @(negedge PCLK); #1;
    chk("rst_bus", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0000);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_data", {PADDR, PWDATA, rsp_rdata}, 24'h0);
    chk("rst_ready", cmd_ready, 0);
    PRESETn = 1'b1;
    #1 chk("ready_after_rst", cmd_ready, 1);

    // Write then read, slave 2, zero wait
    issue(1'b1, 1'b1, 8'h3C, 8'hA5, 0, 0, a); drain();
    issue(1'b0, 1'b1, 8'h3C, 8'h00, 0, 0, a); drain();

    // Slave isolation
    issue(1'b1, 1'b0, 8'h05, 8'h11, 0, 0, a); drain();
    issue(1'b1, 1'b1, 8'h05, 8'h22, 0, 0, a); drain();
    issue(1'b0, 1'b0, 8'h05, 8'h00, 0, 0, a); drain();
    issue(1'b0, 1'b1, 8'h05, 8'h00, 0, 0, a); drain();

    // Wait states: 3 stalled ACCESS cycles on slave 1
    issue(1'b0, 1'b0, 8'h80, 8'h00, 3, 0, a); drain();

    // Timeout on slave 2, then a normal transfer
    issue(1'b0, 1'b1, 8'h3C, 8'h00, 0, 1, a); drain();
    chk("to_bus_idle", {PSEL1, PSEL2, PENABLE}, 3'b000);
    tie[1] = 0;
    issue(1'b0, 1'b1, 8'h3C, 8'h00, 1, 0, a); drain();

    // Reset during a stalled ACCESS
    issue(1'b0, 1'b0, 8'h10, 8'h00, 0, 1, a);
    @(negedge PCLK); #1 cmd_valid = 1'b0;
    @(negedge PCLK); #1;
    chk("mid_in_access", {PSEL1, PENABLE}, 2'b11);
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("mid_rst_bus", {PSEL1, PSEL2, PENABLE}, 3'b000);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    q.delete(); nsel = 0; noth = 0; seen = 0;
    @(negedge PCLK); #1;
    PRESETn = 1'b1; tie[0] = 0;
    #1 chk("mid_rel_ready", cmd_ready, 1);
    @(negedge PCLK); #1;
    chk("mid_no_rsp", rsp_valid, 0);

    // Back-to-back: 4 commands with cmd_valid held high
    issue(1'b1, 1'b0, 8'h20, 8'h6B, 0, 0, prev);
    issue(1'b1, 1'b1, 8'h20, 8'h94, 0, 0, a); chk("b2b_spacing", a - prev, 3); prev = a;
    issue(1'b0, 1'b0, 8'h20, 8'h00, 0, 0, a); chk("b2b_spacing", a - prev, 3); prev = a;
    issue(1'b0, 1'b1, 8'h20, 8'h00, 0, 0, a); chk("b2b_spacing", a - prev, 3);
    drain();

    // Short random mix
    for (int i = 0; i < 10; i++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      ad  = 8'h40 + 8'($urandom_range(0, 3));
      wd  = 8'($urandom);
      w   = $urandom_range(0, 2);
      issue(wr, sel, ad, wd, w, 0, a);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that drives the two-slave APB bus (slave select 1 or 2, 8-bit address, 8-bit data).
- Accepts one command at a time on a valid/ready interface and sequences IDLE→SETUP→ACCESS.
- Waits on the selected slave's PREADY, with an optional timeout.
- Returns read data or write completion on a one-cycle response strobe.

Parameters:
- TIMEOUT_CYCLES, 16: max ACCESS cycles with PREADY low before abort; 0 disables timeout.
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_sel  in  1  0=slave 1, 1=slave 2.
- cmd_addr  in  8  target address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid.
- PSEL1  out  1  select slave 1.
- PSEL2  out  1  select slave 2.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address.
- PWDATA  out  8  APB write data.
- PRDATA1  in  8  read data from slave 1.
- PRDATA2  in  8  read data from slave 2.
- PREADY1  in  1  ready from slave 1.
- PREADY2  in  1  ready from slave 2.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous active-low on PRESETn; it is sampled only at the PCLK rising edge.
- Reset values: state=IDLE; PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0.
- cmd_ready = (state==IDLE) & PRESETn, so it is 0 in any cycle where PRESETn is low.
- States: IDLE, SETUP, ACCESS.
- IDLE: PSELx=0, PENABLE=0. On cmd_valid & cmd_ready at an edge:
  - Latch PWRITE=cmd_write, PADDR=cmd_addr, PWDATA = cmd_write ? cmd_wdata : 0, and the selected slave.
  - Go to SETUP.
- SETUP (exactly 1 cycle): the selected PSELx=1, the other PSELx=0, PENABLE=0. Next state is ACCESS; clear the counter.
- ACCESS: selected PSELx=1, PENABLE=1. Sample PREADY_sel (PREADY1 or PREADY2 per the latched select) at each edge:
  - PREADY_sel=1: transfer completes.
    - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata = PRDATA_sel sampled at that edge for reads, 0 for writes.
    - PSELx=0, PENABLE=0, state=IDLE.
  - PREADY_sel=0 and TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: abort.
    - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - Bus is deasserted, state=IDLE.
  - Otherwise: counter+1, stay in ACCESS.
- Stability: PADDR, PWRITE and PWDATA are constant from SETUP through the last ACCESS cycle. They hold their last values in IDLE and change only on command acceptance.
- The unselected slave never sees PSEL. PENABLE is never 1 without a PSELx.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata and rsp_err hold until the next response.
- Latency: a command accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero wait states, rsp_valid and cmd_ready are both high in cycle N+3, so a new command can be accepted in the same cycle as the response. This gives a minimum of 3 cycles per transfer.
- PREADY of the unselected slave is ignored. PREADY_sel in IDLE or SETUP is ignored.
- Reset mid-transfer: PRESETn low at any edge forces IDLE and deasserts the bus. No rsp_valid is issued for the aborted command.
- The counter saturates and never wraps; with TIMEOUT_CYCLES=0 the bridge waits indefinitely.

Test Plan:
- Write then read, slave 2, zero-wait: write sel=1, addr=0x3C, wdata=0xA5; then read the same address. Required: PSEL2 high for 2 cycles per transfer, PSEL1 never high; read response rsp_valid=1, rsp_rdata=0xA5, rsp_err=0; cmd_ready returns 3 cycles after accept.
- Slave isolation: write 0x11 to slave 1 addr 0x05 and 0x22 to slave 2 addr 0x05, then read both. Required: responses 0x11 and 0x22 respectively.
- Wait states: hold PREADY1=0 for 3 ACCESS cycles on a read of 0x80 returning 0x5A. Required: PADDR, PWRITE and PENABLE stable throughout; rsp_valid exactly once; rsp_rdata=0x5A; total 6 cycles.
- Timeout with TIMEOUT_CYCLES=4: PREADY2 tied 0. Required: 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; bus idle; next command accepted normally.
- Reset mid-ACCESS: drive PRESETn=0 for 1 cycle during a stalled read. Required: the next cycle shows PSEL1=PSEL2=PENABLE=0, state IDLE, no rsp_valid, cmd_ready=1 after release.
- Back-to-back: hold cmd_valid high for 4 commands. Required: exactly 4 responses in order, one accept per 3 cycles, no PSEL glitch between transfers.
